// File: rtl/fifo_traffic_checker_if.sv
// FIFO-side handshake bundle between the traffic checker (master) and the FIFO under test (slave).
interface fifo_traffic_checker_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_full;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;

  modport master (
    output fifo_wr_en, fifo_wr_data, fifo_rd_en,
    input  fifo_full, fifo_rd_data, fifo_empty
  );

  modport slave (
    input  fifo_wr_en, fifo_wr_data, fifo_rd_en,
    output fifo_full, fifo_rd_data, fifo_empty
  );
endinterface

// File: rtl/fifo_traffic_checker.sv
// Traffic generator and self-checker for the FIFO IP: writes a descending-count pattern,
// drains it under one of four scheduling modes and counts data mismatches.
module fifo_traffic_checker #(
  parameter int          DATA_WIDTH = 16,
  parameter int          LEN_WIDTH  = 18,
  parameter int          RD_LATENCY = 1,
  parameter int          BURST_LEN  = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          ERR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [LEN_WIDTH-1:0]   xfer_len,
  fifo_traffic_checker_if.master fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   err_cnt,
  output logic [LEN_WIDTH-1:0]   first_err_idx,
  output logic [LEN_WIDTH-1:0]   wr_count,
  output logic [LEN_WIDTH-1:0]   rd_count
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int FC_W = $clog2(RD_LATENCY + 1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [15:0]           lfsr, lfsr_d;
  logic                  wr_phase, wr_phase_d;
  logic [BC_W-1:0]       burst_cnt, burst_cnt_d;
  logic [LEN_WIDTH-1:0]  wr_count_d, rd_count_d;
  logic [FC_W-1:0]       flush_cnt;
  logic                  wr_req_q, wr_req_d;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [LEN_WIDTH-1:0]  pipe_idx [RD_LATENCY];
  logic [ERR_WIDTH-1:0]  err_d;

  logic                  start_ok, all_moved, flush_last, run_next;
  logic                  wr_fire, rd_fire, rd_allow, wr_allow_d, chk_err, end_err;
  logic [1:0]            mode_d;
  logic [LEN_WIDTH-1:0]  len_d;
  logic [DATA_WIDTH-1:0] exp_word;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign all_moved  = (wr_count == len_q) && (rd_count == len_q);
  assign flush_last = (state == FLUSH) && (flush_cnt == FC_W'(RD_LATENCY - 1));
  assign run_next   = start_ok ? (xfer_len != '0) : ((state == RUN) && !all_moved);
  assign mode_d     = start_ok ? mode : mode_q;
  assign len_d      = start_ok ? xfer_len : len_q;

  always_comb begin
    case (mode_q)
      2'd0:    rd_allow = (wr_count == len_q);
      2'd1:    rd_allow = 1'b1;
      2'd2:    rd_allow = !wr_phase;
      default: rd_allow = lfsr[1];
    endcase
  end

  // The write request is registered one cycle ahead; gating with full keeps the FIFO from overflowing
  // when the last free slot is taken by the write already in flight.
  assign fifo.fifo_wr_en   = wr_req_q && !fifo.fifo_full;
  assign fifo.fifo_rd_en   = (state == RUN) && rd_allow && !fifo.fifo_empty && (rd_count < len_q);
  assign fifo.fifo_wr_data = (state == RUN) ? ALL_ONES - DATA_WIDTH'(wr_count) : '0;
  assign wr_fire = fifo.fifo_wr_en;
  assign rd_fire = fifo.fifo_rd_en;

  assign exp_word = ALL_ONES - DATA_WIDTH'(pipe_idx[RD_LATENCY-1]);
  assign chk_err  = pipe_vld[RD_LATENCY-1] && (fifo.fifo_rd_data != exp_word);
  assign end_err  = flush_last && !fifo.fifo_empty;
  assign err_d    = sat_inc(sat_inc(err_cnt, chk_err), end_err);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    lfsr_d      = lfsr;
    wr_phase_d  = wr_phase;
    burst_cnt_d = burst_cnt;
    wr_count_d  = wr_count + LEN_WIDTH'(wr_fire);
    rd_count_d  = rd_count + LEN_WIDTH'(rd_fire);
    if (start_ok) begin
      lfsr_d      = LFSR_SEED;
      wr_phase_d  = 1'b1;
      burst_cnt_d = '0;
      wr_count_d  = '0;
      rd_count_d  = '0;
    end else if (state == RUN) begin
      lfsr_d = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (wr_fire) begin
        if ((burst_cnt == BC_W'(BURST_LEN - 1)) || (wr_count_d == len_q)) begin
          wr_phase_d  = 1'b0;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt + 1'b1;
        end
      end
      // Read burst ends once everything written so far has been drained.
      if (rd_fire && (rd_count_d == wr_count)) wr_phase_d = 1'b1;
    end

    case (mode_d)
      2'd0, 2'd1: wr_allow_d = 1'b1;
      2'd2:       wr_allow_d = wr_phase_d;
      default:    wr_allow_d = lfsr_d[0];
    endcase
    wr_req_d = run_next && (wr_count_d < len_d) && wr_allow_d;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state         <= IDLE;
      mode_q        <= '0;
      len_q         <= '0;
      lfsr          <= LFSR_SEED;
      wr_phase      <= 1'b1;
      burst_cnt     <= '0;
      wr_count      <= '0;
      rd_count      <= '0;
      wr_req_q      <= 1'b0;
      flush_cnt     <= '0;
      pipe_vld      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
      lfsr      <= lfsr_d;
      wr_phase  <= wr_phase_d;
      burst_cnt <= burst_cnt_d;
      wr_count  <= wr_count_d;
      rd_count  <= rd_count_d;
      wr_req_q  <= wr_req_d;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      pipe_vld[0] <= rd_fire;
      for (int k = 1; k < RD_LATENCY; k++) pipe_vld[k] <= pipe_vld[k-1];

      case (state)
        IDLE, DONE: if (start) begin
          state  <= (xfer_len == '0) ? FLUSH : RUN;
          busy   <= 1'b1;
          done   <= 1'b0;
        end
        RUN:   if (all_moved) state <= FLUSH;
        FLUSH: if (flush_last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_d == '0);
        end
        default: state <= IDLE;
      endcase

      if (start_ok) begin
        mode_q        <= mode;
        len_q         <= xfer_len;
        err_cnt       <= '0;
        first_err_idx <= '1;
        pass          <= 1'b0;
      end else begin
        err_cnt <= err_d;
        if (chk_err && (first_err_idx == '1)) first_err_idx <= pipe_idx[RD_LATENCY-1];
      end
    end
  end

  // NOTE: the index pipe is left unreset; its entries are only consumed when the matching valid bit is set.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= rd_count;
    for (int k = 1; k < RD_LATENCY; k++) pipe_idx[k] <= pipe_idx[k-1];
  end

endmodule
